// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, constants and leading-zero helper for the 7-segment scan driver
package seg7_pkg;
  localparam int MAX_DIGITS = 8;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_OFF = 7'h7F;
  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] value;
    logic [MAX_DIGITS-1:0]   blank;
    logic [MAX_DIGITS-1:0]   dp;
  } display_frame_t;
  localparam display_frame_t FRAME_RST = '{value: '0, blank: '1, dp: '0};
  // A digit stays lit if it, or any digit above it, holds a non-zero nibble or a lit dp.
  function automatic logic [MAX_DIGITS-1:0] lz_blank(logic [4*MAX_DIGITS-1:0] v, logic [MAX_DIGITS-1:0] dp, int n);
    logic keep;
    logic [MAX_DIGITS-1:0] m;
    keep = 1'b0;
    m = '0;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      keep = keep | ((i < n) && (v[i*4 +: 4] != 4'h0 || dp[i]));
      m[i] = !keep;
    end
    return m;
  endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: data load bus and display pin group of the 7-segment scan driver
interface seg7_scan_driver_if #(parameter int NUM_DIGITS = 6);
  import seg7_pkg::*;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   dp;
  seg7_t                   seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_tick;
  modport master (output load, value, blank, dp, input seg_n, dp_n, an_n, frame_tick);
  modport slave (input load, value, blank, dp, output seg_n, dp_n, an_n, frame_tick);
endinterface

// File: rtl/seg7_scan_driver_hex.sv
// hexto7seg: hex nibble to low-active a..g segment pattern (bit0 = a)
module hexto7seg import seg7_pkg::*; (
  input  logic [3:0] hex,
  output seg7_t      seg
);
  localparam logic [111:0] TAB = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
                                  7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  assign seg = TAB[{3'b000, hex} * 7'd7 +: 7];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: tear-free multiplexed common-anode 7-segment scanner with guard interval.
// Define SEG7_LZ_BLANK_EN to blank leading zeros when a frame is committed.
module seg7_scan_driver import seg7_pkg::*; #(
  parameter int NUM_DIGITS   = 6,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 64
) (
  input logic              clk,
  input logic              reset_n,
  seg7_scan_driver_if.slave bus
);
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [SW-1:0]  slot;
  logic [IW-1:0]  idx;
  logic [2:0]     ix;
  logic [3:0]     nib;
  logic           wrap, frame_end, active, lit;
  seg7_t          dec;
  display_frame_t pending, display, in_frame, commit;
  assign in_frame  = '{value: (4*MAX_DIGITS)'(bus.value), blank: MAX_DIGITS'(bus.blank), dp: MAX_DIGITS'(bus.dp)};
  assign wrap      = slot == SW'(SLOT_CYCLES - 1);
  assign frame_end = wrap && idx == IW'(NUM_DIGITS - 1);
  assign active    = int'(slot) >= GUARD_CYCLES;
  assign ix        = 3'(idx);
  assign nib       = display.value[{ix, 2'b00} +: 4];
  assign lit       = active && !display.blank[ix];
`ifdef SEG7_LZ_BLANK_EN
  always_comb begin
    commit = bus.load ? in_frame : pending;
    commit.blank = commit.blank | lz_blank(commit.value, commit.dp, NUM_DIGITS);
  end
`else
  assign commit = bus.load ? in_frame : pending;
`endif
  hexto7seg u_dec (.hex(nib), .seg(dec));
  // Outputs are registered from the same counter state so anode and segments switch together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot           <= '0;
      idx            <= '0;
      pending        <= FRAME_RST;
      display        <= FRAME_RST;
      bus.seg_n      <= SEG_OFF;
      bus.dp_n       <= 1'b1;
      bus.an_n       <= '1;
      bus.frame_tick <= 1'b0;
    end else begin
      slot <= wrap ? '0 : slot + 1'b1;
      if (wrap) idx <= frame_end ? '0 : idx + 1'b1;
      if (bus.load) pending <= in_frame;
      if (frame_end) display <= commit;
      bus.frame_tick <= frame_end;
      bus.an_n       <= active ? ~(NUM_DIGITS'(1) << idx) : '1;
      bus.seg_n      <= lit ? dec : SEG_OFF;
      bus.dp_n       <= !(lit && display.dp[ix]);
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed frame-by-frame checks of the 7-segment scan driver
module tb_seg7_scan_driver;
  import seg7_pkg::*;
  localparam int N = 6, SLOT = 8, GUARD = 2, FR = N * SLOT;
  localparam logic [41:0] DARK = {6{7'h7F}};
  localparam logic [41:0] SCAN = {7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E};
  logic clk = 1'b0, reset_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [6:0] seg_q [FR];
  logic [5:0] an_q [FR];
  logic       dp_q [FR];
  logic       ft_q [FR];
  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();
  seg7_scan_driver #(.NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Runs one frame from a frame boundary, loading va at iteration ka and vb at kb.
  task automatic run_frame(input int ka, input logic [23:0] va, input int kb, input logic [23:0] vb,
                           input logic [5:0] bl, input logic [5:0] dpv);
    for (int k = 0; k < FR; k++) begin
      bus.load  = (k == ka) || (k == kb);
      bus.value = (k == kb) ? vb : va;
      bus.blank = bl;
      bus.dp    = dpv;
      @(posedge clk); #1;
      seg_q[k] = bus.seg_n;
      an_q[k]  = bus.an_n;
      dp_q[k]  = bus.dp_n;
      ft_q[k]  = bus.frame_tick;
    end
    bus.load = 1'b0;
  endtask
  task automatic check_frame(input string tag, input logic [41:0] es, input logic [5:0] edp);
    for (int k = 0; k < FR; k++) begin
      int d, s;
      logic [5:0] ea;
      logic [6:0] eseg;
      d = k / SLOT;
      s = k % SLOT;
      ea = (s < GUARD) ? 6'h3F : ~(6'b1 << d);
      eseg = es[d*7 +: 7];
      chk($sformatf("%s an d%0d s%0d", tag, d, s), 32'(an_q[k]), 32'(ea));
      if (s >= GUARD) begin
        chk($sformatf("%s seg d%0d s%0d", tag, d, s), 32'(seg_q[k]), 32'(eseg));
        chk($sformatf("%s dp d%0d s%0d", tag, d, s), 32'(dp_q[k]), 32'(edp[d]));
      end
      chk($sformatf("%s tick k%0d", tag, k), 32'(ft_q[k]), 32'(k == FR - 1));
    end
  endtask
  initial begin
    bus.load = 1'b0; bus.value = '0; bus.blank = '0; bus.dp = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst seg", 32'(bus.seg_n), 32'h7F);
    chk("rst an", 32'(bus.an_n), 32'h3F);
    chk("rst dp", 32'(bus.dp_n), 32'h1);
    chk("rst tick", 32'(bus.frame_tick), 32'h0);
    reset_n = 1'b1;
    run_frame(10, 24'h12AB0F, -1, 24'h0, 6'h00, 6'h00);
    check_frame("dark", DARK, 6'h3F);
    run_frame(-1, 24'h0, -1, 24'h0, 6'h00, 6'h00);
    check_frame("scan", SCAN, 6'h3F);
    run_frame(5, 24'h111111, 30, 24'h222222, 6'h00, 6'h00);
    check_frame("tear_old", SCAN, 6'h3F);
    run_frame(-1, 24'h0, -1, 24'h0, 6'h00, 6'h00);
    check_frame("tear_new", {6{7'h24}}, 6'h3F);
    run_frame(FR - 1, 24'h000007, -1, 24'h0, 6'h00, 6'h00);
    check_frame("bnd_old", {6{7'h24}}, 6'h3F);
    run_frame(3, 24'h888888, -1, 24'h0, 6'b000010, 6'b000001);
`ifdef SEG7_LZ_BLANK_EN
    check_frame("bnd_new", {{5{7'h7F}}, 7'h78}, 6'h3F);
`else
    check_frame("bnd_new", {{5{7'h40}}, 7'h78}, 6'h3F);
`endif
    run_frame(-1, 24'h0, -1, 24'h0, 6'h00, 6'h00);
    check_frame("blank_dp", {7'h00, 7'h00, 7'h00, 7'h00, 7'h7F, 7'h00}, 6'b111110);
`ifdef SEG7_LZ_BLANK_EN
    run_frame(3, 24'h000050, -1, 24'h0, 6'h00, 6'h00);
    check_frame("blank_dp2", {7'h00, 7'h00, 7'h00, 7'h00, 7'h7F, 7'h00}, 6'b111110);
    run_frame(3, 24'h000000, -1, 24'h0, 6'h00, 6'h00);
    check_frame("lz50", {{4{7'h7F}}, 7'h12, 7'h40}, 6'h3F);
    run_frame(3, 24'h000005, -1, 24'h0, 6'h00, 6'b001000);
    check_frame("lz0", {{5{7'h7F}}, 7'h40}, 6'h3F);
    run_frame(-1, 24'h0, -1, 24'h0, 6'h00, 6'h00);
    check_frame("lzdp", {7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h12}, 6'b110111);
`endif
    bus.load = 1'b1; bus.value = 24'h123456; bus.blank = '0; bus.dp = '0;
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst seg", 32'(bus.seg_n), 32'h7F);
    chk("mid_rst an", 32'(bus.an_n), 32'h3F);
    chk("mid_rst dp", 32'(bus.dp_n), 32'h1);
    chk("mid_rst tick", 32'(bus.frame_tick), 32'h0);
    reset_n = 1'b1;
    run_frame(-1, 24'h0, -1, 24'h0, 6'h00, 6'h00);
    check_frame("post_rst", DARK, 6'h3F);
    run_frame(-1, 24'h0, -1, 24'h0, 6'h00, 6'h00);
    check_frame("post_rst2", DARK, 6'h3F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
